// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped L1 instruction cache.
package icache_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_LSB     = 4;

  typedef enum logic [1:0] {
    LOOKUP,
    REFILL,
    WRITE
  } state_e;

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped cache; produces the lookup hit.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: tag storage is not reset; the valid bits alone decide whether an entry is usable.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) tag_mem[wr_idx_i] <= wr_tag_i;
  end

  assign hit_o = valid_q[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/l1_icache_ctrl.sv
// Direct-mapped L1 instruction cache controller with zero-cycle hits and 3-state refill FSM.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module l1_icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [31:0]       cpu_inst_o,
  output logic              cpu_valid_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              Valid_cache2memory_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              Valid_memory2cache_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LADR_W = ADDR_W - OFFSET_LSB;
  localparam int TAG_W  = LADR_W - IDX_W;

  state_e            state_q, state_d;
  logic [LADR_W-1:0] miss_addr_q, miss_addr_d;

  logic [1:0]        word_off;
  logic [IDX_W-1:0]  lookup_idx;
  logic [TAG_W-1:0]  lookup_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              hit;
  logic              refill_done;
  logic              array_we;
  logic              lookup_hit;
  logic              lookup_miss;
  line_t             rd_line;
  line_t             data_mem [NUM_LINES];
  logic              unused_addr_bits;

  assign word_off         = cpu_addr_i[3:2];
  assign lookup_idx       = cpu_addr_i[OFFSET_LSB +: IDX_W];
  assign lookup_tag       = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign miss_idx         = miss_addr_q[IDX_W-1:0];
  assign miss_tag         = miss_addr_q[LADR_W-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // A refill edge that coincides with reset must leave the arrays untouched.
  assign array_we = refill_done && !rst_i;

  icache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tag_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx_i (lookup_idx),
    .rd_tag_i (lookup_tag),
    .hit_o    (hit),
    .wr_en_i  (array_we),
    .wr_idx_i (miss_idx),
    .wr_tag_i (miss_tag)
  );

  always_ff @(posedge clk_i) begin
    if (array_we) data_mem[miss_idx] <= line_t'(mem_line_i);
  end

  assign rd_line = data_mem[lookup_idx];

  always_comb begin
    state_d              = state_q;
    miss_addr_d          = miss_addr_q;
    cpu_inst_o           = '0;
    cpu_valid_o          = 1'b0;
    stall_o              = 1'b0;
    mem_addr_o           = '0;
    Valid_cache2memory_o = 1'b0;
    refill_done          = 1'b0;
    lookup_hit           = 1'b0;
    lookup_miss          = 1'b0;

    unique case (state_q)
      LOOKUP: begin
        if (cpu_req_i) begin
          if (hit) begin
            lookup_hit  = 1'b1;
            cpu_valid_o = 1'b1;
            cpu_inst_o  = rd_line[word_off];
          end else begin
            lookup_miss = 1'b1;
            stall_o     = 1'b1;
            miss_addr_d = cpu_addr_i[ADDR_W-1:OFFSET_LSB];
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o              = 1'b1;
        Valid_cache2memory_o = 1'b1;
        mem_addr_o           = {miss_addr_q, {OFFSET_LSB{1'b0}}};
        if (Valid_memory2cache_i) begin
          refill_done = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        stall_o = 1'b1;
        state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= LOOKUP;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, lookup_hit};
    miss_cnt_d = miss_cnt_q + {31'd0, lookup_miss};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_l1_icache_ctrl.sv
// Directed self-checking bench for l1_icache_ctrl; counter checks run when ICACHE_PERF_EN is defined.
module tb_l1_icache_ctrl;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_inst;
  logic         cpu_valid;
  logic         stall;
  logic [31:0]  mem_addr;
  logic         mem_req;
  logic [127:0] mem_line;
  logic         mem_valid;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_B = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_C = 128'h90000003_90000002_90000001_90000000;
  localparam logic [127:0] JUNK   = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

  l1_icache_ctrl #(
    .NUM_LINES (64),
    .ADDR_W    (32),
    .LINE_W    (128)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .cpu_req_i            (cpu_req),
    .cpu_addr_i           (cpu_addr),
    .cpu_inst_o           (cpu_inst),
    .cpu_valid_o          (cpu_valid),
    .stall_o              (stall),
    .mem_addr_o           (mem_addr),
    .Valid_cache2memory_o (mem_req),
    .mem_line_i           (mem_line),
    .Valid_memory2cache_i (mem_valid)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o            (hit_cnt),
    .miss_cnt_o           (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] inst);
    check({tag, "_valid"}, 32'(cpu_valid), 32'd1);
    check({tag, "_inst"},  cpu_inst,       inst);
    check({tag, "_stall"}, 32'(stall),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_valid = 1'b0; mem_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_valid",    32'(cpu_valid), 32'd0);
    check("rst_stall",    32'(stall),     32'd0);
    check("rst_mem_req",  32'(mem_req),   32'd0);
    check("rst_mem_addr", mem_addr,       32'h0);
    check("rst_inst",     cpu_inst,       32'h0);

    // Cold miss at 0x104; memory answers on the second REFILL cycle.
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'h0000_0104; #1;
    check("cold_stall",   32'(stall),     32'd1);
    check("cold_novalid", 32'(cpu_valid), 32'd0);
    check("cold_noreq",   32'(mem_req),   32'd0);
    @(negedge clk); #1;
    check("refill1_req",  32'(mem_req),   32'd1);
    check("refill1_addr", mem_addr,       32'h0000_0100);
    check("refill1_stall",32'(stall),     32'd1);
    @(negedge clk); #1;
    check("refill2_req",  32'(mem_req),   32'd1);
    check("refill2_addr", mem_addr,       32'h0000_0100);
    mem_valid = 1'b1; mem_line = LINE_A;
    @(negedge clk); mem_valid = 1'b0; mem_line = '0; #1;
    check("write_stall",  32'(stall),     32'd1);
    check("write_noreq",  32'(mem_req),   32'd0);
    check("write_novalid",32'(cpu_valid), 32'd0);
    @(negedge clk); #1;
    expect_hit("retry_104", 32'hBBBBBBBB);

    // Back-to-back hits within the filled line.
    @(negedge clk); cpu_addr = 32'h0000_0100; #1; expect_hit("hit_100", 32'hAAAAAAAA);
    @(negedge clk); cpu_addr = 32'h0000_0108; #1; expect_hit("hit_108", 32'hCCCCCCCC);
    @(negedge clk); cpu_addr = 32'h0000_010F; #1; expect_hit("hit_10c", 32'hDDDDDDDD);

    // Memory valid during LOOKUP must not disturb the arrays.
    @(negedge clk); cpu_addr = 32'h0000_0100; mem_valid = 1'b1; mem_line = JUNK; #1;
    expect_hit("spur_100", 32'hAAAAAAAA);
    @(negedge clk); mem_valid = 1'b0; cpu_addr = 32'h0000_0104; #1;
    expect_hit("spur_104", 32'hBBBBBBBB);

    // Conflict at index 16 with memory valid held high: 3-cycle penalty.
    @(negedge clk); cpu_addr = 32'h0000_0500; mem_valid = 1'b1; mem_line = LINE_B; #1;
    check("conf_stall",   32'(stall),     32'd1);
    check("conf_novalid", 32'(cpu_valid), 32'd0);
    @(negedge clk); #1;
    check("conf_req",     32'(mem_req),   32'd1);
    check("conf_addr",    mem_addr,       32'h0000_0500);
    @(negedge clk); #1;
    check("conf_wr_stall",32'(stall),     32'd1);
    check("conf_wr_noreq",32'(mem_req),   32'd0);
    @(negedge clk); #1;
    expect_hit("conf_500", 32'h11111111);
    @(negedge clk); mem_valid = 1'b0; cpu_addr = 32'h0000_0100; #1;
    check("evict_stall",  32'(stall),     32'd1);
    check("evict_novalid",32'(cpu_valid), 32'd0);

    // Reset while refilling 0x100.
    @(negedge clk); #1;
    check("mid_req",      32'(mem_req),   32'd1);
    check("mid_addr",     mem_addr,       32'h0000_0100);
    rst = 1'b1; cpu_req = 1'b0; mem_valid = 1'b1; mem_line = JUNK;
    @(negedge clk); rst = 1'b0; mem_valid = 1'b0; mem_line = '0; #1;
    check("post_rst_req",   32'(mem_req), 32'd0);
    check("post_rst_stall", 32'(stall),   32'd0);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0500; #1;
    check("post_rst_500_novalid", 32'(cpu_valid), 32'd0);
    check("post_rst_500_stall",   32'(stall),     32'd1);
    cpu_addr = 32'h0000_0100; #1;
    check("post_rst_100_novalid", 32'(cpu_valid), 32'd0);
    check("post_rst_100_stall",   32'(stall),     32'd1);
    cpu_req = 1'b0; #1;

    // One miss followed by three hits at 0x200.
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'h0000_0200; mem_valid = 1'b1; mem_line = LINE_C; #1;
    check("perf_miss_stall", 32'(stall), 32'd1);
    @(negedge clk);
    @(negedge clk); mem_valid = 1'b0; mem_line = '0;
    @(negedge clk); #1; expect_hit("perf_200", 32'h90000000);
    @(negedge clk); cpu_addr = 32'h0000_0204; #1; expect_hit("perf_204", 32'h90000001);
    @(negedge clk); cpu_addr = 32'h0000_0208; #1; expect_hit("perf_208", 32'h90000002);
    @(negedge clk); cpu_req = 1'b0; #1;
    check("idle_valid", 32'(cpu_valid), 32'd0);
    check("idle_inst",  cpu_inst,       32'h0);
`ifdef ICACHE_PERF_EN
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt",  hit_cnt,  32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/l1_icache_ctrl.md
Name: l1_icache_ctrl

Overview:
- Direct-mapped L1 instruction cache, placed between the fetch stage and the 128-bit line-read instruction memory.
- Serves 32-bit instruction words to fetch on hits.
- On a miss: stalls fetch, issues one line-aligned request to instruction memory, waits for the memory valid, writes the 4-word line, then resumes.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, minimum 2.
- ADDR_W, 32, byte address width.
- LINE_W, 128, line width in bits; fixed at 4 x 32-bit words.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cpu_req_i  in  1  fetch request valid.
- cpu_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- cpu_inst_o  out  32  instruction word.
- cpu_valid_o  out  1  cpu_inst_o valid this cycle (hit).
- stall_o  out  1  fetch must hold PC.
- mem_addr_o  out  32  line-aligned refill address; bits [3:0] = 0.
- Valid_cache2memory_o  out  1  refill request.
- mem_line_i  in  128  refill line; word k at bits [32k+31:32k].
- Valid_memory2cache_i  in  1  mem_line_i valid.

Behaviour:
- Address split:
  - word offset = addr[3:2]
  - index = addr[4+IDX_W-1:4], where IDX_W = log2(NUM_LINES)
  - tag = addr[31:4+IDX_W]; 22 bits at the default NUM_LINES.
- Storage: flop arrays for valid bits, tags and line data. Data array may be a RAM with combinational read.
- Reset (rst_i = 1 at an edge):
  - all valid bits cleared; FSM goes to LOOKUP.
  - outputs: cpu_valid_o = 0, stall_o = 0, Valid_cache2memory_o = 0, mem_addr_o = 0, cpu_inst_o = 0.
  - Reset asserted mid-refill abandons the refill. No array write occurs in the reset cycle.
- FSM states: LOOKUP, REFILL, WRITE.
- LOOKUP:
  - hit = cpu_req_i & valid[index] & (tag match). Evaluated combinationally in the same cycle.
  - On hit: cpu_valid_o = 1, stall_o = 0, cpu_inst_o = the selected word. Zero-cycle hit latency.
  - On miss (cpu_req_i & !hit): stall_o = 1 in the same cycle and cpu_valid_o = 0. At the edge, latch {tag, index} into miss_addr and go to REFILL.
  - cpu_req_i = 0: cpu_valid_o = 0, stall_o = 0, cpu_inst_o = 0.
- REFILL:
  - Valid_cache2memory_o = 1, mem_addr_o = {miss_addr, 4'b0}, stall_o = 1.
  - Valid_cache2memory_o stays high until Valid_memory2cache_i = 1 is sampled.
  - On that edge: capture mem_line_i into the data array at the latched index, set the tag and valid bit, go to WRITE.
- WRITE:
  - one bubble cycle: stall_o = 1, Valid_cache2memory_o = 0. Next state LOOKUP.
  - The retried fetch then hits.
  - Minimum miss penalty: 3 cycles (miss, REFILL with immediate valid, WRITE).
- Valid_memory2cache_i sampled in LOOKUP or WRITE is ignored.
- A constantly-high memory valid completes REFILL in its first cycle.
- cpu_addr_i or cpu_req_i changing during REFILL/WRITE has no effect on the refill. The lookup in LOOKUP uses the current address.
- A refill replaces the line at that index unconditionally (eviction).

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0].
  - counters increment on each LOOKUP-state hit / miss-detect cycle respectively.
  - both reset to 0 by rst_i; wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg holds:
  - state enum {LOOKUP, REFILL, WRITE}
  - LINE_W and WORDS_PER_LINE = 4
  - OFFSET_LSB = 4
- Sub-module icache_tag_array (valid+tag storage, compare, hit output) is natural.
- Data array and FSM stay in the top.

Test Plan:
- Cold miss:
  - Stimulus: reset, then cpu_req_i = 1, cpu_addr_i = 0x0000_0104; memory returns valid 2 cycles later with line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
  - Required: stall_o = 1 immediately; Valid_cache2memory_o = 1 with mem_addr_o = 0x0000_0100 until valid; one WRITE bubble; then cpu_valid_o = 1 with cpu_inst_o = 0xBBBBBBBB.
- Hits within the line: addresses 0x100, 0x108, 0x10C after the fill -> 0xAAAAAAAA, 0xCCCCCCCC, 0xDDDDDDDD on consecutive cycles, stall_o = 0 throughout.
- Conflict eviction (NUM_LINES = 64):
  - Stimulus: fetch 0x0000_0500 after filling 0x0000_0100 (same index 16, different tag).
  - Required: miss, refill at 0x500; a subsequent fetch of 0x100 misses again.
- Reset mid-refill:
  - Stimulus: assert rst_i while in REFILL.
  - Required: next cycle Valid_cache2memory_o = 0, stall_o = 0; a fetch of the previously filled 0x100 misses.
- Spurious/held valid:
  - Valid_memory2cache_i = 1 while in LOOKUP -> no array change.
  - Valid_memory2cache_i held high -> miss completes with a 3-cycle penalty.
- ICACHE_PERF_EN defined: 1 cold miss + 3 hits -> miss_cnt_o = 1, hit_cnt_o = 3.
